// File: rtl/snake_body_shifter.sv
// Snake tail shifter: moves tail slots down one position per move and writes old head to slot 0.
// Optional self-collision detection is enabled with `define SELF_COLLISION_EN.
module snake_body_shifter #(
  parameter int WORD_W = 12,
  parameter int ADDR_W = 7,
  parameter int MAX_TAILS = 128,
  parameter int CNT_W = 8,
  parameter logic [WORD_W-1:0] RESET_HEAD = 12'h820
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              move_req,
  input  logic [WORD_W-1:0] next_head,
  input  logic              grow,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] head_pos,
  output logic [CNT_W-1:0]  num_tails,
  output logic              busy,
  output logic              done,
  output logic              grow_sat,
  output logic              collision
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_HEAD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  idx_m1;
  logic [CNT_W-1:0]  start_idx;
  logic [WORD_W-1:0] new_head;
  logic [WORD_W-1:0] old_head;
  logic              grow_q;
  logic              eff_q;
  logic              eff_grow;

  always_comb begin
    eff_grow  = grow && (num_tails < CNT_W'(MAX_TAILS));
    start_idx = eff_grow ? num_tails : num_tails - CNT_W'(1);
    idx_m1    = idx - CNT_W'(1);
  end

`ifdef SELF_COLLISION_EN
  logic hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (move_req) hit <= 1'b0;
        S_WRITE: if (mem_rdata == new_head) hit <= 1'b1;
        S_HEAD:  if (old_head == new_head) hit <= 1'b1;
        default: ;
      endcase
    end
  end

  // Result stays visible after done until the next accept clears it.
  assign collision = hit && (state == S_DONE || state == S_IDLE);
`else
  assign collision = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      new_head  <= '0;
      old_head  <= '0;
      grow_q    <= 1'b0;
      eff_q     <= 1'b0;
      head_pos  <= RESET_HEAD;
      num_tails <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (move_req) begin
            new_head <= next_head;
            old_head <= head_pos;
            grow_q   <= grow;
            eff_q    <= eff_grow;
            idx      <= start_idx;
            if (num_tails == '0 && !eff_grow)
              state <= S_DONE;
            else if (start_idx >= CNT_W'(1))
              state <= S_READ;
            else
              state <= S_HEAD;
          end
        end
        S_READ: state <= S_WRITE;
        S_WRITE: begin
          idx   <= idx_m1;
          state <= (idx_m1 >= CNT_W'(1)) ? S_READ : S_HEAD;
        end
        S_HEAD: state <= S_DONE;
        S_DONE: begin
          head_pos <= new_head;
          if (eff_q) num_tails <= num_tails + CNT_W'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    done      = 1'b0;
    grow_sat  = 1'b0;
    case (state)
      S_READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = idx_m1[ADDR_W-1:0];
      end
      S_WRITE: begin
        mem_wr_en = 1'b1;
        mem_addr  = idx[ADDR_W-1:0];
        mem_wdata = mem_rdata;
      end
      S_HEAD: begin
        mem_wr_en = 1'b1;
        mem_wdata = old_head;
      end
      S_DONE: begin
        done     = 1'b1;
        grow_sat = grow_q && !eff_q;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_snake_body_shifter.sv
// Scoreboard bench for snake_body_shifter with a behavioural tail RAM.
// Expected collision values follow `define SELF_COLLISION_EN.
module tb_snake_body_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        move_req = 1'b0;
  logic [11:0] next_head = '0;
  logic        grow = 1'b0;
  logic [6:0]  mem_addr;
  logic        mem_rd_en;
  logic [11:0] mem_rdata = '0;
  logic        mem_wr_en;
  logic [11:0] mem_wdata;
  logic [11:0] head_pos;
  logic [7:0]  num_tails;
  logic        busy;
  logic        done;
  logic        grow_sat;
  logic        collision;

`ifdef SELF_COLLISION_EN
  localparam logic COL_EXP = 1'b1;
`else
  localparam logic COL_EXP = 1'b0;
`endif

  snake_body_shifter dut (
    .clk(clk), .reset(reset), .move_req(move_req),
    .next_head(next_head), .grow(grow),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .head_pos(head_pos),
    .num_tails(num_tails), .busy(busy), .done(done),
    .grow_sat(grow_sat), .collision(collision)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lat;
    logic [11:0] head;
    logic [7:0]  n;
    logic        gs;
    logic        col;
  } exp_t;

  exp_t        sq[$];
  logic [18:0] wlog[$];
  logic [11:0] ram [128];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_en) begin
      ram[mem_addr] <= mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_rd_en === 1'b1 && mem_wr_en === 1'b1) begin
      total++;
      bad++;
      $display("FAIL strobe_overlap: rd_en and wr_en both high at cycle %0d", cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] wl(input int i);
    return (i < wlog.size()) ? wlog[i] : 19'h7ffff;
  endfunction

  // Monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no done");
        end else begin
          e = sq.pop_front();
          check("latency", cyc - acc_cyc + 1, e.lat);
          check("grow_sat", grow_sat, e.gs);
          check("collision", collision, e.col);
          @(negedge clk);
          check("head_pos", head_pos, e.head);
          check("num_tails", num_tails, e.n);
          check("busy_after", busy, 0);
          check("collision_held", collision, e.col);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic move(input logic [11:0] nh, input logic g, input int lat,
                      input logic [11:0] eh, input logic [7:0] en,
                      input logic gs, input logic col, input bit poke = 0);
    bit seen;
    sq.push_back('{lat, eh, en, gs, col});
    @(negedge clk);
    wlog.delete();
    move_req = 1'b1;
    next_head = nh;
    grow = g;
    @(posedge clk);
    #1 acc_cyc = cyc;
    seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      move_req = (poke && k == 1);
      if (poke && k == 1) next_head = 12'hfff;
      if (done === 1'b1) seen = 1;
    end
    move_req = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done want done within 400 cycles");
      sq.delete();
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic build_col();
    do_reset();
    move(12'h412, 1'b0, 1, 12'h412, 8'd0, 1'b0, 1'b0);
    move(12'h411, 1'b1, 2, 12'h411, 8'd1, 1'b0, 1'b0);
    move(12'h410, 1'b1, 4, 12'h410, 8'd2, 1'b0, 1'b0);
    move(12'h400, 1'b1, 6, 12'h400, 8'd3, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_head", head_pos, 12'h820);
    check("rst_tails", num_tails, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobes", {mem_rd_en, mem_wr_en}, 0);

    move(12'h821, 1'b1, 2, 12'h821, 8'd1, 1'b0, 1'b0);
    check("first_wcount", wlog.size(), 1);
    check("first_w0", wl(0), {7'd0, 12'h820});

    move(12'h822, 1'b1, 4, 12'h822, 8'd2, 1'b0, 1'b0);
    move(12'h823, 1'b1, 6, 12'h823, 8'd3, 1'b0, 1'b0);
    check("abc_slot0", ram[0], 12'h822);
    check("abc_slot2", ram[2], 12'h820);

    // poke=1 drives an extra move_req while busy; it must be ignored
    move(12'h824, 1'b0, 6, 12'h824, 8'd3, 1'b0, 1'b0, 1);
    check("shift_wcount", wlog.size(), 3);
    check("shift_w0", wl(0), {7'd2, 12'h821});
    check("shift_w1", wl(1), {7'd1, 12'h822});
    check("shift_w2", wl(2), {7'd0, 12'h823});
    check("shift_slot0", ram[0], 12'h823);
    check("shift_slot1", ram[1], 12'h822);
    check("shift_slot2", ram[2], 12'h821);

    do_reset();
    move(12'h830, 1'b0, 1, 12'h830, 8'd0, 1'b0, 1'b0);
    check("skip_wcount", wlog.size(), 0);
    move(12'h831, 1'b1, 2, 12'h831, 8'd1, 1'b0, 1'b0);

    @(negedge clk);
    move_req = 1'b1;
    next_head = 12'h777;
    grow = 1'b1;
    @(negedge clk);
    move_req = 1'b0;
    check("abort_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_head", head_pos, 12'h820);
    check("abort_tails", num_tails, 0);
    check("abort_strobes", {mem_rd_en, mem_wr_en}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    move(12'h555, 1'b1, 2, 12'h555, 8'd1, 1'b0, 1'b0);
    check("abort_w0", wl(0), {7'd0, 12'h820});

    build_col();
    move(12'h411, 1'b0, 6, 12'h411, 8'd3, 1'b0, COL_EXP);
    build_col();
    move(12'h412, 1'b0, 6, 12'h412, 8'd3, 1'b0, 1'b0);

    do_reset();
    for (int k = 0; k < 128; k++)
      move(12'(k + 1), 1'b1, 2 * k + 2, 12'(k + 1), 8'(k + 1), 1'b0, 1'b0);
    move(12'habc, 1'b1, 256, 12'habc, 8'd128, 1'b1, 1'b0);
    check("sat_wcount", wlog.size(), 128);
    check("sat_slot0", ram[0], 12'h080);
    check("sat_slot1", ram[1], 12'h07f);
    check("sat_slot127", ram[127], 12'h001);

    repeat (3) @(negedge clk);
    check("sb_empty", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "global timeout");
  end

endmodule
